// File: rtl/mod_pow_ctrl.sv
// rtl/mod_pow_ctrl.sv - modular exponentiation controller driving an external mod-mul engine
// Right-to-left square-and-multiply; one outstanding multiplier request at a time.
module mod_pow_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] mod,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_m,
    input  logic [WIDTH-1:0] mul_result,
    input  logic             mul_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_FINISH
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_SQR
    } op_t;

    state_t           state;
    state_t           next_state;
    op_t              op;
    logic [WIDTH-1:0] b_val;
    logic [WIDTH-1:0] e_val;
    logic [WIDTH-1:0] acc;
    logic             mod_trivial;
    logic             e_last;

    assign mod_trivial = (mod <= WIDTH'(1));
    assign e_last      = ((e_val >> 1) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mul_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                next_state = mod_trivial ? S_FINISH : S_CHECK;
            end
            S_CHECK: begin
                next_state = (e_val == '0) ? S_FINISH : S_ISSUE;
            end
            S_ISSUE: begin
                mul_start  = 1'b1;
                next_state = S_WAIT_LO;
            end
            // The engine's done is still high from its previous idle period; wait for it to drop.
            S_WAIT_LO: begin
                if (!mul_done) begin
                    next_state = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (mul_done) begin
                    if (op == OP_MUL) begin
                        next_state = e_last ? S_FINISH : S_ISSUE;
                    end else begin
                        next_state = S_CHECK;
                    end
                end
            end
            S_FINISH: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            done   <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
            mul_m  <= '0;
            b_val  <= '0;
            e_val  <= '0;
            acc    <= '0;
            op     <= OP_MUL;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= !start;
                end
                S_LOAD: begin
                    b_val <= base;
                    e_val <= exp;
                    mul_m <= mod;
                    acc   <= mod_trivial ? WIDTH'(0) : WIDTH'(1);
                end
                S_CHECK: begin
                    if (e_val != '0) begin
                        if (e_val[0]) begin
                            op    <= OP_MUL;
                            mul_a <= acc;
                            mul_b <= b_val;
                        end else begin
                            op    <= OP_SQR;
                            mul_a <= b_val;
                            mul_b <= b_val;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (mul_done) begin
                        if (op == OP_MUL) begin
                            acc <= mul_result;
                            // Last set bit consumed: the trailing square would be wasted work.
                            if (e_last) begin
                                e_val <= '0;
                            end else begin
                                op    <= OP_SQR;
                                mul_a <= b_val;
                                mul_b <= b_val;
                            end
                        end else begin
                            b_val <= mul_result;
                            e_val <= e_val >> 1;
                        end
                    end
                end
                S_FINISH: begin
                    result <= acc;
                    done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_pow_ctrl.sv
// tb/tb_mod_pow_ctrl.sv - self-checking bench for mod_pow_ctrl with a behavioural mod-mul engine
module tb_mod_pow_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base;
    logic [31:0] exp;
    logic [31:0] mod;
    logic [31:0] result;
    logic        done;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_m;
    logic [31:0] mul_result;
    logic        mul_done;

    int n_assert = 0;
    int n_fail   = 0;

    int          pulses    = 0;
    int          stab_err  = 0;
    int          proto_err = 0;
    int          lat_min   = 1;
    int          lat_max   = 40;
    logic [31:0] cur_mod   = '0;

    logic [63:0] op_q[$];
    logic [31:0] res_q[$];
    int          cnt_q[$];

    always #5 clk = ~clk;

    mod_pow_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base       (base),
        .exp        (exp),
        .mod        (mod),
        .result     (result),
        .done       (done),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_m      (mul_m),
        .mul_result (mul_result),
        .mul_done   (mul_done)
    );

    // Behavioural multiplier: done drops after a request, rises with the product after a random latency.
    logic              busy = 1'b0;
    logic              hold = 1'b0;
    int                lat_cnt = 0;
    logic [31:0]       cap_a, cap_b;
    longint unsigned   prod;
    logic [63:0]       exp_op;

    always @(posedge clk) begin
        if (reset) begin
            mul_done   <= 1'b1;
            mul_result <= '0;
            busy = 1'b0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                hold = 1'b0;
                if (mul_a !== cap_a || mul_b !== cap_b) stab_err++;
            end
            if (mul_start === 1'b1) begin
                pulses++;
                if (busy || mul_done !== 1'b1) proto_err++;
                if (mul_m !== cur_mod) proto_err++;
                cap_a = mul_a;
                cap_b = mul_b;
                if (mul_m == 0) prod = 0;
                else prod = (longint'(mul_a) * longint'(mul_b)) % longint'(mul_m);
                if (op_q.size() > 0) begin
                    exp_op = op_q.pop_front();
                    n_assert++;
                    if ({mul_a, mul_b} !== exp_op) begin
                        n_fail++;
                        $display("FAIL op_operands: got a=%0d b=%0d, expected a=%0d b=%0d",
                                 mul_a, mul_b, exp_op[63:32], exp_op[31:0]);
                    end
                end
                lat_cnt = $urandom_range(lat_max, lat_min);
                busy = 1'b1;
                mul_done <= 1'b0;
            end else if (busy) begin
                if (mul_a !== cap_a || mul_b !== cap_b) stab_err++;
                if (lat_cnt <= 1) begin
                    mul_done   <= 1'b1;
                    mul_result <= prod[31:0];
                    busy = 1'b0;
                    hold = 1'b1;
                end else begin
                    lat_cnt--;
                end
            end
        end
    end

    function automatic logic [31:0] golden(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        longint unsigned r, x;
        if (m <= 1) return 32'd0;
        r = 1;
        x = b;
        while (e != 0) begin
            if (e[0]) r = (r * x) % m;
            x = (x * x) % m;
            e = e >> 1;
        end
        return r[31:0];
    endfunction

    function automatic int golden_reqs(input logic [31:0] e, input logic [31:0] m);
        int n = 0;
        int msb = 0;
        if (m <= 1 || e == 0) return 0;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) begin
                n++;
                msb = i;
            end
        end
        return n + msb;
    endfunction

    task automatic run_job(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                           output logic [31:0] r, output int np, output bit timed_out);
        int p0;
        base    = b;
        exp     = e;
        mod     = m;
        cur_mod = m;
        p0      = pulses;
        start   = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        r  = result;
        np = pulses - p0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        base  = '0;
        exp   = '0;
        mod   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        if ({result, done, mul_start, mul_a, mul_b, mul_m} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got result=%0d done=%0b mul_start=%0b a=%0d b=%0d m=%0d, expected all 0",
                     result, done, mul_start, mul_a, mul_b, mul_m);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_assert++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle_done: got %0b, expected 1", done);
        end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        int np;
        bit to;
        lat_min = 1;
        lat_max = 40;
        op_q.push_back({32'd1, 32'd3});
        op_q.push_back({32'd3, 32'd3});
        op_q.push_back({32'd2, 32'd2});
        op_q.push_back({32'd3, 32'd4});
        res_q.push_back(32'd5);
        cnt_q.push_back(4);
        run_job(32'd3, 32'd5, 32'd7, r, np, to);
        n_assert++;
        if (to) begin
            n_fail++;
            $display("FAIL basic_timeout: done never rose");
        end
        n_assert++;
        if (r !== res_q[0]) begin
            n_fail++;
            $display("FAIL basic_result: got %0d, expected %0d", r, res_q[0]);
        end
        void'(res_q.pop_front());
        n_assert++;
        if (np !== cnt_q[0]) begin
            n_fail++;
            $display("FAIL basic_pulses: got %0d, expected %0d", np, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
        n_assert++;
        if (op_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_ops_left: got %0d unissued, expected 0", op_q.size());
        end
        op_q.delete();
    endtask

    task automatic test_pow_2_10();
        logic [31:0] r;
        int np;
        bit to;
        res_q.push_back(32'd24);
        cnt_q.push_back(5);
        run_job(32'd2, 32'd10, 32'd1000, r, np, to);
        n_assert++;
        if (to || r !== res_q[0]) begin
            n_fail++;
            $display("FAIL pow_2_10_result: got %0d (timeout=%0b), expected %0d", r, to, res_q[0]);
        end
        void'(res_q.pop_front());
        n_assert++;
        if (np !== cnt_q[0]) begin
            n_fail++;
            $display("FAIL pow_2_10_pulses: got %0d, expected %0d", np, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
    endtask

    task automatic test_edge();
        logic [31:0] r;
        int np;
        bit to;
        logic [31:0] tb_b[3] = '{32'd5, 32'd5, 32'd0};
        logic [31:0] tb_m[3] = '{32'd13, 32'd1, 32'd0};
        logic [31:0] tb_e[3] = '{32'd0, 32'd9, 32'd9};
        for (int i = 0; i < 3; i++) begin
            res_q.push_back(golden(tb_b[i], tb_e[i], tb_m[i]));
            run_job(tb_b[i], tb_e[i], tb_m[i], r, np, to);
            n_assert++;
            if (to || r !== res_q[0]) begin
                n_fail++;
                $display("FAIL edge_result[%0d]: got %0d (timeout=%0b), expected %0d", i, r, to, res_q[0]);
            end
            void'(res_q.pop_front());
            n_assert++;
            if (np !== 0) begin
                n_fail++;
                $display("FAIL edge_pulses[%0d]: got %0d, expected 0", i, np);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        res_q.push_back(32'd5);
        res_q.push_back(32'd9);
        base    = 32'd3;
        exp     = 32'd5;
        mod     = 32'd7;
        cur_mod = 32'd7;
        start   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        base = 32'd4;
        exp  = 32'd3;
        mod  = 32'd11;
        for (int i = 0; i < 5000; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (i > 2) cur_mod = 32'd7;
            @(posedge clk); #1;
        end
        n_assert++;
        if (!seen || result !== res_q[0]) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d (seen=%0b), expected %0d", result, seen, res_q[0]);
        end
        void'(res_q.pop_front());
        cur_mod = 32'd11;
        @(posedge clk); #1;
        n_assert++;
        if (done !== 1'b0 || result !== 32'd5) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got done=%0b result=%0d, expected done=0 result=5", done, result);
        end
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_assert++;
        if (!seen || result !== res_q[0]) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d (seen=%0b), expected %0d", result, seen, res_q[0]);
        end
        void'(res_q.pop_front());
    endtask

    task automatic test_reset_mid_job();
        logic [31:0] r;
        int np, p0, p1;
        bit to;
        bit reached = 1'b0;
        lat_min = 20;
        lat_max = 20;
        base    = 32'd3;
        exp     = 32'd5;
        mod     = 32'd7;
        cur_mod = 32'd7;
        p0      = pulses;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (pulses - p0 >= 2) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_assert++;
        if (!reached) begin
            n_fail++;
            $display("FAIL midjob_progress: got %0d pulses, expected 2", pulses - p0);
        end
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_assert++;
        if ({result, done, mul_start, mul_a, mul_b, mul_m} !== '0) begin
            n_fail++;
            $display("FAIL midjob_reset_outputs: got result=%0d done=%0b mul_start=%0b a=%0d b=%0d m=%0d, expected all 0",
                     result, done, mul_start, mul_a, mul_b, mul_m);
        end
        reset = 1'b0;
        p1 = pulses;
        repeat (30) @(posedge clk);
        #1;
        n_assert++;
        if (pulses !== p1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL midjob_quiet: got %0d extra pulses done=%0b, expected 0 pulses done=1", pulses - p1, done);
        end
        lat_min = 1;
        lat_max = 40;
        res_q.push_back(32'd5);
        run_job(32'd3, 32'd5, 32'd7, r, np, to);
        n_assert++;
        if (to || r !== res_q[0] || np !== 4) begin
            n_fail++;
            $display("FAIL midjob_fresh: got %0d pulses=%0d (timeout=%0b), expected %0d pulses=4", r, np, to, res_q[0]);
        end
        void'(res_q.pop_front());
    endtask

    task automatic test_random();
        logic [31:0] b, e, m, r;
        int np;
        bit to;
        lat_min = 1;
        lat_max = 4;
        for (int j = 0; j < 300; j++) begin
            m = $urandom & 32'h7fff_ffff;
            if (j % 50 == 0) m = 32'(j % 3);
            b = (m == 0) ? 32'd0 : ($urandom % m);
            e = $urandom & 32'h0000_ffff;
            res_q.push_back(golden(b, e, m));
            cnt_q.push_back(golden_reqs(e, m));
            run_job(b, e, m, r, np, to);
            n_assert++;
            if (to || r !== res_q[0]) begin
                n_fail++;
                $display("FAIL random_result[%0d]: b=%0d e=%0d m=%0d got %0d (timeout=%0b), expected %0d",
                         j, b, e, m, r, to, res_q[0]);
            end
            void'(res_q.pop_front());
            n_assert++;
            if (np !== cnt_q[0]) begin
                n_fail++;
                $display("FAIL random_pulses[%0d]: got %0d, expected %0d", j, np, cnt_q[0]);
            end
            void'(cnt_q.pop_front());
            if (to) break;
        end
    endtask

    task automatic test_protocol();
        n_assert++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL operand_stability: got %0d violations, expected 0", stab_err);
        end
        n_assert++;
        if (proto_err !== 0) begin
            n_fail++;
            $display("FAIL handshake_protocol: got %0d violations, expected 0", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pow_2_10();
        test_edge();
        test_back_to_back();
        test_reset_mid_job();
        test_random();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
